// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Misses fetch a single word from the memory controller over iREN/iwait.
//   state | meaning
//   IDLE  | lookup current fetch address, launch a fill on a miss
//   FILL  | hold iREN on miss_addr until the controller drops iwait
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - IDX - 2;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SETS-1:0]  r_valid;
  logic [TAG-1:0]   r_tag  [SETS];
  logic [31:0]      r_data [SETS];
  logic [31:0]      r_miss_addr;

  logic [IDX-1:0]   w_idx;
  logic [TAG-1:0]   w_tag;
  logic [IDX-1:0]   w_fill_idx;
  logic             w_hit;
  logic             w_fill_we;
  logic             w_miss_latch;

  assign w_idx      = imemaddr[IDX+1:2];
  assign w_tag      = imemaddr[31:IDX+2];
  assign w_fill_idx = r_miss_addr[IDX+1:2];
  assign w_hit      = imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    w_next       = r_state;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = r_miss_addr;
    w_fill_we    = 1'b0;
    w_miss_latch = 1'b0;
    case (r_state)
      IDLE: begin
        ihit = w_hit;
        if (w_hit) imemload = r_data[w_idx];
        if (imemREN && !w_hit) begin
          w_miss_latch = 1'b1;
          w_next       = FILL;
        end
      end
      FILL: begin
        iREN = 1'b1;
        if (!iwait) begin
          w_fill_we = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_miss_addr <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_miss_latch) r_miss_addr <= {imemaddr[31:2], 2'b00};
      if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; valid alone gates their use.
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= r_miss_addr[31:IDX+2];
      r_data[w_fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (SETS=16).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  int n_cmp = 0;
  int n_err = 0;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Miss on addr, hold iwait high for `waits` FILL cycles, then return data;
  // ends checking the hit in the cycle after the fill.
  task automatic do_fill(input logic [31:0] addr, input int waits, input logic [31:0] data);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1;
    chk("miss_ihit", {31'b0, ihit}, 32'h0);
    chk("miss_iren", {31'b0, iREN}, 32'h0);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      #1;
      chk("wait_iren", {31'b0, iREN}, 32'h1);
      chk("wait_iaddr", iaddr, addr);
      chk("wait_ihit", {31'b0, ihit}, 32'h0);
    end
    @(negedge CLK);
    iwait = 1'b0; iload = data;
    #1;
    chk("done_iren", {31'b0, iREN}, 32'h1);
    chk("done_iaddr", iaddr, addr);
    chk("done_ihit", {31'b0, ihit}, 32'h0);
    @(negedge CLK);
    iwait = 1'b1; iload = 32'hDEAD_BEEF;
    #1;
    chk("fill_ihit", {31'b0, ihit}, 32'h1);
    chk("fill_load", imemload, data);
    chk("fill_iren", {31'b0, iREN}, 32'h0);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iload = 32'h0; iwait = 1'b1;
    #2;
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // idle with cold cache
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      imemaddr = 32'h40 * i;
      #1;
      chk("idle_ihit", {31'b0, ihit}, 32'h0);
      chk("idle_iren", {31'b0, iREN}, 32'h0);
    end

    do_fill(32'h0, 3, 32'h2008_0005);

    @(negedge CLK);
    imemaddr = 32'h0;
    #1;
    chk("rehit0_ihit", {31'b0, ihit}, 32'h1);
    chk("rehit0_load", imemload, 32'h2008_0005);
    @(negedge CLK);
    imemaddr = 32'h2;
    #1;
    chk("off2_ihit", {31'b0, ihit}, 32'h1);
    chk("off2_load", imemload, 32'h2008_0005);
    chk("off2_iren", {31'b0, iREN}, 32'h0);

    // conflict: same index, different tag
    do_fill(32'h40, 0, 32'h1111_0040);
    do_fill(32'h0, 1, 32'h2008_0005);

    // redirect during FILL
    @(negedge CLK);
    imemaddr = 32'h10; iwait = 1'b1;
    #1;
    chk("rd_miss_ihit", {31'b0, ihit}, 32'h0);
    @(negedge CLK);
    imemaddr = 32'h20;
    #1;
    chk("rd_iren1", {31'b0, iREN}, 32'h1);
    chk("rd_iaddr1", iaddr, 32'h10);
    chk("rd_ihit1", {31'b0, ihit}, 32'h0);
    @(negedge CLK);
    #1;
    chk("rd_iaddr2", iaddr, 32'h10);
    @(negedge CLK);
    iwait = 1'b0; iload = 32'hAAAA_0010;
    #1;
    chk("rd_iaddr3", iaddr, 32'h10);
    chk("rd_iren3", {31'b0, iREN}, 32'h1);
    @(negedge CLK);
    iwait = 1'b1;
    #1;
    chk("rd20_ihit", {31'b0, ihit}, 32'h0);
    chk("rd20_iren", {31'b0, iREN}, 32'h0);
    @(negedge CLK);
    iwait = 1'b0; iload = 32'hBBBB_0020;
    #1;
    chk("rd20_fill_iren", {31'b0, iREN}, 32'h1);
    chk("rd20_fill_iaddr", iaddr, 32'h20);
    @(negedge CLK);
    iwait = 1'b1;
    #1;
    chk("rd20_hit", {31'b0, ihit}, 32'h1);
    chk("rd20_load", imemload, 32'hBBBB_0020);
    @(negedge CLK);
    imemaddr = 32'h10;
    #1;
    chk("rd10_hit", {31'b0, ihit}, 32'h1);
    chk("rd10_load", imemload, 32'hAAAA_0010);

    // reset during FILL
    @(negedge CLK);
    imemaddr = 32'h30;
    #1;
    chk("rs_miss", {31'b0, ihit}, 32'h0);
    @(negedge CLK);
    #1;
    chk("rs_fill_iren", {31'b0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    chk("rs_iren", {31'b0, iREN}, 32'h0);
    chk("rs_iaddr", iaddr, 32'h0);
    chk("rs_ihit", {31'b0, ihit}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    imemaddr = 32'h0;  #1; chk("post_rs_0", {31'b0, ihit}, 32'h0);
    imemaddr = 32'h10; #1; chk("post_rs_10", {31'b0, ihit}, 32'h0);
    imemaddr = 32'h20; #1; chk("post_rs_20", {31'b0, ihit}, 32'h0);
    imemaddr = 32'h30; #1; chk("post_rs_30", {31'b0, ihit}, 32'h0);
    chk("post_rs_iren", {31'b0, iREN}, 32'h0);
    @(negedge CLK);
    #1;
    chk("post_rs_refill", {31'b0, iREN}, 32'h1);
    chk("post_rs_iaddr", iaddr, 32'h30);
    imemREN = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache serving the fetch stage of the pipelined datapath. It is the cache-side responder for the instruction half of `datapath_cache_if`: it answers `imemREN`/`imemaddr` with `ihit`/`imemload`. On a miss it fetches one word from the memory controller over an `iREN`/`iaddr`/`iload`/`iwait` handshake. It sits between the datapath and the memory arbiter, one instance per core.

## Interface
Parameters:
- `SETS`, default 16: number of one-word frames; power of two, ≥2. `IDX = log2(SETS)`; `TAG = 32 - IDX - 2`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address. `[1:0]` are ignored. Index is `[IDX+1:2]`; tag is `[31:IDX+2]`.
- `ihit`  out  1  fetch satisfied this cycle; combinational.
- `imemload`  out  32  instruction word; valid when `ihit=1`, else `32'h0`.
- `iREN`  out  1  read request to the memory controller.
- `iaddr`  out  32  word-aligned address for `iREN`.
- `iload`  in  32  memory read data; sampled when `iwait=0`.
- `iwait`  in  1  memory busy; `0` means `iload` is valid this cycle.

## Operation
- Storage per frame: `valid` (1), `tag` (TAG), `data` (32). Only `valid` is reset.
- `hit = imemREN && valid[idx] && (tag[idx] == imemaddr tag)`. The hit logic is purely combinational from the current `imemaddr`.
- FSM states: `IDLE`, `FILL`.
  - `IDLE`:
    - `iREN=0`.
    - `ihit=hit`, and `imemload=data[idx]` on a hit.
    - If `imemREN && !hit`: latch `{imemaddr[31:2],2'b00}` into `miss_addr` and go to `FILL`.
  - `FILL`:
    - `iREN=1`, `iaddr=miss_addr`, `ihit=0`, `imemload=0`.
    - Stay while `iwait=1`.
    - On a cycle with `iwait=0`: write `data=iload`, `tag=miss_addr tag`, `valid=1` into frame `miss_addr` index, then go to `IDLE`.
- Fills always complete to `miss_addr`, even if `imemaddr` changes or `imemREN` drops during `FILL`. This covers branch redirects. After returning to `IDLE`, the current `imemaddr` is looked up anew.
- Replacement: a fill unconditionally overwrites the indexed frame (direct-mapped).
- No write path and no invalidate. Instruction memory is treated as immutable after reset.
- `iaddr` outside `FILL` drives `miss_addr` (`32'h0` after reset); it is don't-care to the controller while `iREN=0`.

## Timing
- Reset (`nRST=0`, asynchronous):
  - state goes to `IDLE`, all `valid` are cleared, `miss_addr` is set to 0.
  - Outputs: `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`.
- Hit latency: 0 cycles. `ihit` is asserted in the same cycle the address is presented.
- Miss latency: the miss is detected in cycle T, and `iREN` rises in T+1. If the controller drops `iwait` in cycle T+1+W, the frame is written at the end of that cycle and `ihit=1` in T+2+W, provided the address is unchanged. Minimum miss penalty is 2 cycles (`W=0`).
- No forwarding of `iload` to `imemload` during `FILL`. `ihit` is never high in `FILL`.
- `iREN` stays high continuously from the start of `FILL` until and including the `iwait=0` cycle. It is low the following cycle.
- Reset asserted mid-`FILL`: `iREN` drops immediately and no frame is written. After reset the pending address misses again.
- `imemREN=0` in `IDLE`: `ihit=0` and no state change.
- The datapath holds the PC until `ihit`. Back-to-back hits to any frames sustain one fetch per cycle.

## Test plan
- Reset, then `imemREN=1`, `imemaddr=0x0`, with memory responding `iwait=1` for 3 cycles and then `iload=0x2008_0005` → `iREN=1`/`iaddr=0x0` for 4 cycles, then `ihit=1` and `imemload=0x2008_0005` on the next cycle.
- After that fill, request `0x0` again and then `0x2` → `ihit=1` in the same cycle both times (offset ignored), with `iREN` remaining 0.
- With `SETS=16`: fill `0x00`, then fill `0x40` (same index, different tag) → `0x40` hits. Re-requesting `0x00` misses with `iaddr=0x00` and `iREN=1`.
- Miss on `0x10`, then change `imemaddr` to `0x20` during `FILL` → `iaddr` stays `0x10` until `iwait=0`. The frame for `0x10` becomes valid, and `0x20` then starts its own miss.
- Assert `nRST=0` during `FILL` and earlier-filled frames → `iREN=0` immediately. Every previously filled address misses after reset is released.
- `imemREN=0` with a cold cache for 5 cycles → `iREN=0` and `ihit=0` throughout, with no fills.
